regfile_write_arbiter: RTL

//  Shares the register file's single write port between two writeback sources.
//  Req0 is the pipeline WB stage; req1 is the multi-cycle unit (mult/div, loads).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/arb_wait_counter.sv | 42 ++++
 rtl/regfile_write_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_pkg                                                              |
// | Shared widths, the $zero address and arbiter state encoding.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE1 = 1'b1
    } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_wait_counter                                                         |
// | Saturating loss counter for the low-priority requester.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module arb_wait_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_max
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign o_at_max = (count_q == CNT_W'(MAX_WAIT));
    assign o_count  = count_q;

    // Clear dominates so a forced grant always restarts the count.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && !o_at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_write_arbiter                                                    |
// | Shares the register-file write port between WB (req0) and the            |
// | multi-cycle unit (req1) with a starvation guard and WAW squash.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0Valid,
    input  logic [ADDR_W-1:0] req0Address,
    input  logic [DATA_W-1:0] req0Data,
    output logic              req0Ready,
    input  logic              req1Valid,
    input  logic [ADDR_W-1:0] req1Address,
    input  logic [DATA_W-1:0] req1Data,
    output logic              req1Ready,
    output logic              writeEn,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [DATA_W-1:0] writeData,
    output logic              starveForce
);
    localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  PRE_MAX   = CNT_W'(MAX_WAIT - 1);

    arb_state_t        state_q, state_d;
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic              w_squash;
    logic              w_ready0, w_ready1;
    logic              w_grant, w_sel1;
    logic              w_inc, w_clr;
    logic [CNT_W-1:0]  w_count;
    logic              w_at_max;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_inc),
        .i_clr    (w_clr),
        .o_count  (w_count),
        .o_at_max (w_at_max)
    );

    // req0 is younger, so an older req1 write to the same register is dead.
    assign w_squash = req0Valid && req1Valid && (req0Address == req1Address)
                      && (req0Address != ZERO_ADDR);

    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        w_grant  = 1'b0;
        w_sel1   = 1'b0;
        w_inc    = 1'b0;
        w_clr    = 1'b0;
        state_d  = state_q;
        if (!rst) begin
            case (state_q)
                NORMAL: begin
                    if (req0Valid) begin
                        w_ready0 = 1'b1;
                        w_grant  = 1'b1;
                        if (w_squash) begin
                            w_ready1 = 1'b1;
                            w_clr    = 1'b1;
                        end else if (req1Valid) begin
                            w_inc = 1'b1;
                        end
                    end else if (req1Valid) begin
                        w_ready1 = 1'b1;
                        w_grant  = 1'b1;
                        w_sel1   = 1'b1;
                        w_clr    = 1'b1;
                    end
                    if ((w_inc && (w_count == PRE_MAX)) || w_at_max) begin
                        state_d = FORCE1;
                    end
                end
                FORCE1: begin
                    w_clr   = 1'b1;
                    state_d = NORMAL;
                    if (req1Valid) begin
                        w_ready1 = 1'b1;
                        w_grant  = 1'b1;
                        w_sel1   = 1'b1;
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    assign w_addr = w_sel1 ? req1Address : req0Address;
    assign w_data = w_sel1 ? req1Data : req0Data;

    // Address/data only move on a real write so they hold across idle cycles.
    always_comb begin
        write_en_d   = w_grant && (w_addr != ZERO_ADDR);
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (write_en_d) begin
            write_addr_d = w_addr;
            write_data_d = w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= NORMAL;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign req0Ready    = w_ready0;
    assign req1Ready    = w_ready1;
    assign writeEn      = write_en_q;
    assign writeAddress = write_addr_q;
    assign writeData    = write_data_q;
    assign starveForce  = (state_q == FORCE1);
endmodule
`default_nettype wire
